// File: rtl/config_sr_pkg.sv
// Shared types and sizing helpers for the config shift-register emulator.
package config_sr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_LOADED = 2'd2
    } state_t;

    // Number of readback words needed to cover the ParallelOut image.
    function automatic int num_words(input int width, input int dw);
        return (width + dw - 1) / dw;
    endfunction

    // Readback address width; one spare code above the last word so an
    // out-of-range index is always expressible.
    function automatic int addr_width(input int nwords);
        return $clog2(nwords + 1);
    endfunction

    // Shift counter width; headroom above WIDTH so over-long frames stay visible.
    function automatic int count_width(input int width);
        return $clog2(width + 1) + 1;
    endfunction

endpackage

// File: rtl/config_sr_emulator_sync_edge_det.sv
// Synchronizer plus history flop for one asynchronous serial control line.
// Edge outputs are held off until the history flop carries a real synced
// sample, so a line that is already high when reset releases gives no edge.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [SYNC_STAGES:0]   prime_q;

    // Synchronizer chain, history sample and post-reset priming chain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            hist_q  <= 1'b0;
            prime_q <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], d};
            hist_q  <= sync_q[SYNC_STAGES-1];
            prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = prime_q[SYNC_STAGES] & level & ~hist_q;
    assign fall  = prime_q[SYNC_STAGES] & ~level & hist_q;

endmodule

// File: rtl/config_sr_emulator.sv
// Chip-side emulation of the ASIC config shift register for loopback
// bring-up of the config controller, with word-wide readback of the
// latched ParallelOut image and framing status.
module config_sr_emulator
    import config_sr_pkg::*;
#(
    parameter  int CONFIG_REG_WIDTH   = 5164,
    parameter  int C_S_AXI_DATA_WIDTH = 32,
    parameter  int SYNC_STAGES        = 2,
    localparam int NUM_WORDS          = num_words(CONFIG_REG_WIDTH, C_S_AXI_DATA_WIDTH),
    localparam int ADDR_W             = addr_width(NUM_WORDS),
    localparam int CNT_W              = count_width(CONFIG_REG_WIDTH)
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    input  logic                          ConfigClk,
    input  logic                          ConfigIn,
    input  logic                          ConfigLoad,
    input  logic                          Reset_not,
    input  logic                          SuperpixSel,
    output logic                          ConfigOut,
    input  logic [ADDR_W-1:0]             rd_addr,
    input  logic                          rd_en,
    output logic [C_S_AXI_DATA_WIDTH-1:0] rd_data,
    output logic                          rd_valid,
    output logic [CNT_W-1:0]              shift_count,
    output logic [15:0]                   load_count,
    output logic                          length_err,
    output logic [1:0]                    state,
    output logic                          superpix_sel
);

    localparam int PAD_W = NUM_WORDS * C_S_AXI_DATA_WIDTH;

    logic clk_level, clk_rise, clk_fall;
    logic load_level, load_rise, load_fall;
    logic rstn_s, rstn_rise, rstn_fall;
    logic unused_sync;

    logic [SYNC_STAGES-1:0] in_sync_q;
    logic [SYNC_STAGES-1:0] sp_sync_q;
    logic                   in_s;

    logic [CONFIG_REG_WIDTH-1:0]   sr_q;
    logic [CONFIG_REG_WIDTH-1:0]   po_q;
    logic [CNT_W-1:0]              shift_count_q;
    logic [15:0]                   load_count_q;
    logic                          length_err_q;
    logic                          superpix_q;
    logic                          cfg_out_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_data_q;
    logic                          rd_valid_q;
    logic [PAD_W-1:0]              po_pad;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;

    state_t state_q, state_d;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_clk_det (
        .clk(S_AXI_ACLK), .rst(S_AXI_ARESET), .d(ConfigClk),
        .level(clk_level), .rise(clk_rise), .fall(clk_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_load_det (
        .clk(S_AXI_ACLK), .rst(S_AXI_ARESET), .d(ConfigLoad),
        .level(load_level), .rise(load_rise), .fall(load_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_rstn_det (
        .clk(S_AXI_ACLK), .rst(S_AXI_ARESET), .d(Reset_not),
        .level(rstn_s), .rise(rstn_rise), .fall(rstn_fall)
    );

    // Only the rising edges and the Reset_not level drive behaviour.
    assign unused_sync = ^{clk_level, clk_fall, load_level, load_fall, rstn_rise, rstn_fall};

    // Data-side synchronizers; same depth as the edge detectors so ConfigIn lines up with its clock edge
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            in_sync_q <= '0;
            sp_sync_q <= '0;
        end else begin
            in_sync_q <= {in_sync_q[SYNC_STAGES-2:0], ConfigIn};
            sp_sync_q <= {sp_sync_q[SYNC_STAGES-2:0], SuperpixSel};
        end
    end

    assign in_s = in_sync_q[SYNC_STAGES-1];

    // Shift register, ParallelOut latch, counters and sticky framing flag
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            sr_q          <= '0;
            po_q          <= '0;
            shift_count_q <= '0;
            load_count_q  <= '0;
            length_err_q  <= 1'b0;
            superpix_q    <= 1'b0;
            cfg_out_q     <= 1'b0;
        end else if (!rstn_s) begin
            sr_q          <= '0;
            po_q          <= '0;
            shift_count_q <= '0;
            cfg_out_q     <= 1'b0;
        end else begin
            if (clk_rise)
                sr_q <= {sr_q[CONFIG_REG_WIDTH-2:0], in_s};
            if (load_rise) begin
                po_q          <= sr_q;
                length_err_q  <= length_err_q | (shift_count_q != CNT_W'(CONFIG_REG_WIDTH));
                load_count_q  <= load_count_q + 16'd1;
                superpix_q    <= sp_sync_q[SYNC_STAGES-1];
                shift_count_q <= clk_rise ? CNT_W'(1) : '0;
            end else if (clk_rise && shift_count_q != {CNT_W{1'b1}}) begin
                shift_count_q <= shift_count_q + CNT_W'(1);
            end
            cfg_out_q <= sr_q[CONFIG_REG_WIDTH-1];
        end
    end

    // FSM state register
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // FSM next state; a load edge takes priority over a same-cycle clock edge
    always_comb begin
        state_d = state_q;
        if (!rstn_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (load_rise) state_d = ST_LOADED;
                           else if (clk_rise) state_d = ST_SHIFT;
                ST_SHIFT:  if (load_rise) state_d = ST_LOADED;
                ST_LOADED: if (!load_rise && clk_rise) state_d = ST_SHIFT;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // FSM output: state is exported directly
    always_comb begin
        state = state_q;
    end

    // Readback mux; bits past the register end and indices past the last word read as zero
    always_comb begin
        po_pad                         = '0;
        po_pad[CONFIG_REG_WIDTH-1:0]   = po_q;
        rd_word                        = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (int'(rd_addr) == i)
                rd_word = po_pad[i*C_S_AXI_DATA_WIDTH +: C_S_AXI_DATA_WIDTH];
        end
    end

    // Registered readback port, one-cycle latency
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en)
                rd_data_q <= rd_word;
        end
    end

    assign ConfigOut    = cfg_out_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign shift_count  = shift_count_q;
    assign load_count   = load_count_q;
    assign length_err   = length_err_q;
    assign superpix_sel = superpix_q;

endmodule

// File: tb/tb_config_sr_emulator.sv
// Directed bench for config_sr_emulator with a 40-bit register and 32-bit readback.
module tb_config_sr_emulator;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        cfg_clk = 1'b0;
    logic        cfg_in = 1'b0;
    logic        cfg_load = 1'b0;
    logic        reset_not = 1'b1;
    logic        spx = 1'b0;
    logic        cfg_out;
    logic [1:0]  rd_addr = 2'd0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [6:0]  shift_count;
    logic [15:0] load_count;
    logic        length_err;
    logic [1:0]  state;
    logic        superpix_sel;

    int passed = 0;
    int total  = 0;

    logic [39:0] model;
    logic [63:0] pat;

    always #5 clk = ~clk;

    config_sr_emulator #(
        .CONFIG_REG_WIDTH(40), .C_S_AXI_DATA_WIDTH(32), .SYNC_STAGES(2)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(areset),
        .ConfigClk(cfg_clk), .ConfigIn(cfg_in), .ConfigLoad(cfg_load),
        .Reset_not(reset_not), .SuperpixSel(spx), .ConfigOut(cfg_out),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .shift_count(shift_count), .load_count(load_count), .length_err(length_err),
        .state(state), .superpix_sel(superpix_sel)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bit(input logic b);
        cfg_in = b;
        wait_cyc(10);
        cfg_clk = 1'b1;
        wait_cyc(10);
        cfg_clk = 1'b0;
    endtask

    task automatic pulse_load();
        wait_cyc(10);
        cfg_load = 1'b1;
        wait_cyc(10);
        cfg_load = 1'b0;
        wait_cyc(10);
    endtask

    task automatic read_word(input logic [1:0] a, input logic [31:0] exp, input string tag);
        rd_addr = a;
        rd_en   = 1'b1;
        @(negedge clk);
        rd_en   = 1'b0;
        chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
        chk(tag, 64'(rd_data), 64'(exp));
        @(negedge clk);
        chk({tag, "_valid_drop"}, 64'(rd_valid), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        wait_cyc(3);
        chk("rst_cfgout", 64'(cfg_out), 64'd0);
        chk("rst_shift_count", 64'(shift_count), 64'd0);
        chk("rst_load_count", 64'(load_count), 64'd0);
        chk("rst_length_err", 64'(length_err), 64'd0);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        areset = 1'b0;
        wait_cyc(10);

        // Correct 40-bit frame 0xA5_1234_5678, MSB first
        pat = 64'h00A5_1234_5678;
        for (int i = 39; i >= 0; i--) shift_bit(pat[i]);
        wait_cyc(4);
        chk("f1_shift_count", 64'(shift_count), 64'd40);
        chk("f1_state_shift", 64'(state), 64'd1);
        spx = 1'b1;
        pulse_load();
        chk("f1_shift_count_cleared", 64'(shift_count), 64'd0);
        chk("f1_length_err", 64'(length_err), 64'd0);
        chk("f1_load_count", 64'(load_count), 64'd1);
        chk("f1_state_loaded", 64'(state), 64'd2);
        chk("f1_superpix", 64'(superpix_sel), 64'd1);
        read_word(2'd0, 32'h1234_5678, "f1_word0");
        read_word(2'd1, 32'h0000_00A5, "f1_word1");
        read_word(2'd2, 32'h0000_0000, "f1_word_oor");

        // 41-bit frame; ConfigOut follows the model MSB after every edge
        model = 40'hA5_1234_5678;
        pat   = 64'h0000_0155_AAC3_96E1;
        spx   = 1'b0;
        for (int i = 40; i >= 0; i--) begin
            model = {model[38:0], pat[i]};
            shift_bit(pat[i]);
            chk($sformatf("f2_cfgout_edge%0d", 41 - i), 64'(cfg_out), 64'(model[39]));
            if (i == 1) chk("f2_first_bit_back", 64'(cfg_out), 64'd1);
        end
        wait_cyc(4);
        chk("f2_shift_count", 64'(shift_count), 64'd41);
        pulse_load();
        chk("f2_length_err_set", 64'(length_err), 64'd1);
        chk("f2_load_count", 64'(load_count), 64'd2);
        chk("f2_superpix", 64'(superpix_sel), 64'd0);
        read_word(2'd0, 32'hAAC3_96E1, "f2_word0");
        read_word(2'd1, 32'h0000_0055, "f2_word1");

        // Correct frame after an error keeps length_err sticky
        pat = 64'h003C_DEAD_BEEF;
        for (int i = 39; i >= 0; i--) shift_bit(pat[i]);
        pulse_load();
        chk("f3_length_err_sticky", 64'(length_err), 64'd1);
        chk("f3_load_count", 64'(load_count), 64'd3);
        read_word(2'd0, 32'hDEAD_BEEF, "f3_word0");
        read_word(2'd1, 32'h0000_003C, "f3_word1");

        // Reset_not low after 17 edges of a new frame
        for (int i = 0; i < 17; i++) shift_bit(1'b1);
        wait_cyc(4);
        chk("rn_shift_count_pre", 64'(shift_count), 64'd17);
        reset_not = 1'b0;
        wait_cyc(6);
        chk("rn_shift_count", 64'(shift_count), 64'd0);
        chk("rn_state", 64'(state), 64'd0);
        chk("rn_cfgout", 64'(cfg_out), 64'd0);
        chk("rn_load_count_kept", 64'(load_count), 64'd3);
        chk("rn_length_err_kept", 64'(length_err), 64'd1);
        read_word(2'd0, 32'h0000_0000, "rn_word0");
        read_word(2'd1, 32'h0000_0000, "rn_word1");
        reset_not = 1'b1;
        wait_cyc(10);

        // Load and clock edges synchronized in the same cycle
        pat = 64'h0000_0000_0000_00C3;
        for (int i = 7; i >= 0; i--) shift_bit(pat[i]);
        cfg_in = 1'b1;
        spx    = 1'b1;
        wait_cyc(10);
        cfg_clk  = 1'b1;
        cfg_load = 1'b1;
        wait_cyc(10);
        cfg_clk  = 1'b0;
        cfg_load = 1'b0;
        wait_cyc(10);
        chk("sim_shift_count", 64'(shift_count), 64'd1);
        chk("sim_load_count", 64'(load_count), 64'd4);
        read_word(2'd0, 32'h0000_00C3, "sim_word0_preshift");

        // Synchronous reset while a clock edge is in flight
        cfg_in = 1'b1;
        wait_cyc(10);
        cfg_clk = 1'b1;
        wait_cyc(5);
        chk("ar_shift_count_pre", 64'(shift_count), 64'd2);
        areset = 1'b1;
        @(negedge clk);
        chk("ar_cfgout", 64'(cfg_out), 64'd0);
        chk("ar_rd_data", 64'(rd_data), 64'd0);
        chk("ar_rd_valid", 64'(rd_valid), 64'd0);
        chk("ar_shift_count", 64'(shift_count), 64'd0);
        chk("ar_load_count", 64'(load_count), 64'd0);
        chk("ar_length_err", 64'(length_err), 64'd0);
        chk("ar_state", 64'(state), 64'd0);
        chk("ar_superpix", 64'(superpix_sel), 64'd0);
        wait_cyc(2);
        areset = 1'b0;
        wait_cyc(8);
        chk("ar_no_shift_on_high", 64'(shift_count), 64'd0);
        chk("ar_state_idle", 64'(state), 64'd0);
        cfg_clk = 1'b0;
        shift_bit(1'b1);
        wait_cyc(2);
        chk("ar_first_real_edge", 64'(shift_count), 64'd1);
        chk("ar_state_shift", 64'(state), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
